// File: rtl/dram_arbiter.sv
// Two-master round-robin arbiter for a single-port DRAM with combinational read.
// Partial-byte stores are done as read-modify-write because the DRAM has no byte enables.
module dram_arbiter #(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] DRAM_BASE = 32'h0000_0000
) (
    input  logic              fpga_clk,
    input  logic              fpga_rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [3:0]        m0_be,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [3:0]        m1_be,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [31:0]       m1_rdata,
    input  logic              m1_lock,
    output logic              busy,
    output logic [ADDR_W-1:0] dram_a,
    output logic [31:0]       dram_d,
    output logic              dram_we,
    input  logic [31:0]       dram_spo
);

    typedef enum logic [1:0] {IDLE, ACCESS, RMW, RESP} state_t;

    localparam logic [32:0] WINDOW_BYTES = 33'd4 << ADDR_W;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_lastGnt;
    logic              r_id;
    logic              r_we;
    logic              r_inRange;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] r_dramA;
    logic [31:0]       r_dramD;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant;
    logic              w_gntId;
    logic              w_selWe;
    logic [31:0]       w_selAddr;
    logic [3:0]        w_selBe;
    logic [31:0]       w_selWdata;
    logic [31:0]       w_offset;
    logic              w_inRange;
    logic              w_partial;
    logic [31:0]       w_merged;
    logic              w_resp;

    // An address below the base wraps to a huge offset, so one compare covers both window edges.
    always_comb begin
        w_elig0    = m0_req & ~m1_lock;
        w_elig1    = m1_req;
        w_grant    = w_elig0 | w_elig1;
        w_gntId    = (w_elig0 & w_elig1) ? ~r_lastGnt : w_elig1;
        w_selWe    = w_gntId ? m1_we    : m0_we;
        w_selAddr  = w_gntId ? m1_addr  : m0_addr;
        w_selBe    = w_gntId ? m1_be    : m0_be;
        w_selWdata = w_gntId ? m1_wdata : m0_wdata;
        w_offset   = w_selAddr - DRAM_BASE;
        w_inRange  = ({1'b0, w_offset} < WINDOW_BYTES);
        w_partial  = r_we & (r_be != 4'hF) & (r_be != 4'h0);
        for (int i = 0; i < 4; i++) begin
            w_merged[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : dram_spo[8*i +: 8];
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        dram_we     = 1'b0;
        w_resp      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                dram_we     = r_inRange & r_we & (r_be == 4'hF);
                w_nextState = (r_inRange & w_partial) ? RMW : RESP;
            end
            RMW: begin
                dram_we     = 1'b1;
                w_nextState = RESP;
            end
            RESP: begin
                w_resp      = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
        // Reset suppresses both the write strobe and any completion in the same cycle.
        if (fpga_rst) begin
            dram_we = 1'b0;
            w_resp  = 1'b0;
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            r_lastGnt <= 1'b1;
            r_id      <= 1'b0;
            r_we      <= 1'b0;
            r_inRange <= 1'b0;
            r_be      <= 4'h0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_dramA   <= '0;
            r_dramD   <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_id      <= w_gntId;
                        r_lastGnt <= w_gntId;
                        r_we      <= w_selWe;
                        r_be      <= w_selBe;
                        r_wdata   <= w_selWdata;
                        r_inRange <= w_inRange;
                        r_dramA   <= w_offset[ADDR_W+1:2];
                        // dram_d only moves when the following cycle actually writes it.
                        if (w_selWe & w_inRange & (w_selBe == 4'hF)) begin
                            r_dramD <= w_selWdata;
                        end
                    end
                end
                ACCESS: begin
                    r_rdata <= (~r_we & r_inRange) ? dram_spo : 32'h0;
                    if (r_inRange & w_partial) begin
                        r_dramD <= w_merged;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m0_ack   = w_resp & ~r_id;
    assign m0_err   = m0_ack & ~r_inRange;
    assign m0_rdata = m0_ack ? r_rdata : 32'h0;
    assign m1_ack   = w_resp & r_id;
    assign m1_err   = m1_ack & ~r_inRange;
    assign m1_rdata = m1_ack ? r_rdata : 32'h0;
    assign busy     = (r_state != IDLE);
    assign dram_a   = r_dramA;
    assign dram_d   = r_dramD;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized two-master traffic.
module tb_dram_arbiter;

    localparam int          ADDR_W = 14;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          DEPTH  = 1 << ADDR_W;

    logic              fpga_clk = 1'b0;
    logic              fpga_rst = 1'b1;
    logic              m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [31:0]       m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [3:0]        m0_be = 0, m1_be = 0;
    logic              m0_ack, m0_err, m1_ack, m1_err, busy, dram_we;
    logic [31:0]       m0_rdata, m1_rdata, dram_d, dram_spo;
    logic [ADDR_W-1:0] dram_a;

    int total = 0;
    int bad   = 0;

    always #5 fpga_clk = ~fpga_clk;

    dram_arbiter #(.ADDR_W(ADDR_W), .DRAM_BASE(BASE)) dut (
        .fpga_clk(fpga_clk), .fpga_rst(fpga_rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .m1_lock(m1_lock), .busy(busy),
        .dram_a(dram_a), .dram_d(dram_d), .dram_we(dram_we), .dram_spo(dram_spo)
    );

    function automatic logic [31:0] initWord(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // DRAM: unwritten words read back a fixed address-derived pattern.
    bit [31:0] memData    [DEPTH];
    bit        memWritten [DEPTH];
    always @(posedge fpga_clk) begin
        if (dram_we) begin
            memData[dram_a]    <= dram_d;
            memWritten[dram_a] <= 1'b1;
        end
    end
    assign dram_spo = memWritten[dram_a] ? memData[dram_a] : initWord(int'(dram_a));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: one transaction at a time, timed in cycles since grant.
    bit [31:0] refData    [DEPTH];
    bit        refWritten [DEPTH];
    bit          modelOn = 0;
    int          lastGnt = 1;
    bit          tIn = 0;
    int          tId, tAge, tLat, tWeAge, tWord;
    bit          tWe, tRange;
    logic [3:0]  tBe;
    logic [31:0] tWdata;

    function automatic logic [31:0] refRead(input int w);
        return refWritten[w] ? refData[w] : initWord(w);
    endfunction

    function automatic bit inWindow(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(DEPTH));
    endfunction

    function automatic int wordOf(input logic [31:0] a);
        return int'(((a - BASE) >> 2) & 32'(DEPTH - 1));
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                               input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? newW[8*i +: 8] : oldW[8*i +: 8];
        return r;
    endfunction

    always @(negedge fpga_clk) begin : compareProc
        bit [1:0]    eAck;
        bit          eWe, eBusy, eErr, e0, e1;
        logic [31:0] eRd, eD, sAddr;
        int          eA, pick;
        if (modelOn) begin
            eAck = 2'b00; eWe = 0; eBusy = 0; eErr = 0; eRd = 0; eD = 0; eA = 0;
            if (tIn) begin
                tAge++;
                eBusy = 1;
                if (tAge == tLat) begin
                    eAck[tId] = !fpga_rst;
                    eErr = !tRange;
                    eRd  = (tRange && !tWe) ? refRead(tWord) : 32'h0;
                end
                if (tWeAge != 0 && tAge == tWeAge && !fpga_rst) begin
                    eWe = 1;
                    eA  = tWord;
                    eD  = mergeBytes(refRead(tWord), tWdata, tBe);
                end
            end
            checkBit("m0_ack", m0_ack, eAck[0]);
            checkBit("m1_ack", m1_ack, eAck[1]);
            if (eAck[0]) begin
                checkBit("m0_err", m0_err, eErr);
                checkOutput("m0_rdata", m0_rdata, eRd);
            end
            if (eAck[1]) begin
                checkBit("m1_err", m1_err, eErr);
                checkOutput("m1_rdata", m1_rdata, eRd);
            end
            checkBit("busy", busy, eBusy);
            checkBit("dram_we", dram_we, eWe);
            if (eWe) begin
                checkOutput("dram_a", 32'(dram_a), 32'(eA));
                checkOutput("dram_d", dram_d, eD);
                refData[eA]    = eD;
                refWritten[eA] = 1'b1;
            end
            if (fpga_rst) begin
                tIn = 0;
                lastGnt = 1;
            end else if (tIn) begin
                if (tAge == tLat) tIn = 0;
            end else begin
                e0 = m0_req && !m1_lock;
                e1 = m1_req;
                if (e0 || e1) begin
                    pick    = (e0 && e1) ? 1 - lastGnt : (e1 ? 1 : 0);
                    lastGnt = pick;
                    tIn     = 1;
                    tAge    = 0;
                    tId     = pick;
                    tWe     = (pick == 1) ? m1_we    : m0_we;
                    sAddr   = (pick == 1) ? m1_addr  : m0_addr;
                    tBe     = (pick == 1) ? m1_be    : m0_be;
                    tWdata  = (pick == 1) ? m1_wdata : m0_wdata;
                    tRange  = inWindow(sAddr);
                    tWord   = wordOf(sAddr);
                    tLat    = 2;
                    tWeAge  = 0;
                    if (tRange && tWe) begin
                        if (tBe == 4'hF) tWeAge = 1;
                        else if (tBe != 4'h0) begin
                            tLat   = 3;
                            tWeAge = 2;
                        end
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int m, input logic req, input logic we, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wdata;
        end
    endtask

    task automatic singleTx(input int m, input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                            output logic er, output int weCnt, output int weK,
                            output logic [31:0] weD, output int weA);
        logic ack;
        lat = -1; rd = 0; er = 0; weCnt = 0; weK = -1; weD = 0; weA = -1;
        @(posedge fpga_clk); #1;
        applyStimulus(m, 1'b1, we, addr, be, wdata);
        for (int k = 0; k < 20; k++) begin
            @(negedge fpga_clk);
            if (dram_we) begin
                weCnt++; weK = k; weD = dram_d; weA = int'(dram_a);
            end
            ack = (m == 0) ? m0_ack : m1_ack;
            if (ack) begin
                lat = k;
                rd  = (m == 0) ? m0_rdata : m1_rdata;
                er  = (m == 0) ? m0_err : m1_err;
                break;
            end
        end
        if (lat < 0) begin
            total++; bad++;
            $display("[TB] FAIL tx_timeout: master %0d got no ack, required one within 20 cycles", m);
        end
        @(posedge fpga_clk); #1;
        applyStimulus(m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic randomTx(input int mixMode, output logic we, output logic [31:0] addr,
                            output logic [3:0] be, output logic [31:0] wdata);
        int r;
        wdata = $urandom;
        if (mixMode == 0) begin
            we = 0; be = 4'hF;
            addr = 32'($urandom_range(0, 15)) * 4;
        end else begin
            we = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 3);
            be = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom);
            r  = $urandom_range(0, 9);
            case (r)
                7:       addr = 32'h0001_0000;
                8:       addr = 32'h0000_FFFC | 32'($urandom_range(0, 3));
                9:       addr = 32'h0002_0010;
                default: addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            endcase
        end
    endtask

    int ackOrder[$];

    task automatic traffic(input int n0, input int n1, input int lockMode, input int mixMode);
        int rem[2];
        bit need[2];
        logic we;
        logic [31:0] addr, wdata;
        logic [3:0] be;
        rem[0] = n0; rem[1] = n1; need[0] = 1; need[1] = 1;
        ackOrder.delete();
        for (int cyc = 0; cyc < 3000 && (rem[0] > 0 || rem[1] > 0); cyc++) begin
            @(posedge fpga_clk); #1;
            for (int m = 0; m < 2; m++) begin
                if (need[m]) begin
                    if (rem[m] > 0) begin
                        randomTx(mixMode, we, addr, be, wdata);
                        applyStimulus(m, 1'b1, we, addr, be, wdata);
                    end else begin
                        applyStimulus(m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
                    end
                    need[m] = 0;
                end
            end
            m1_lock = (lockMode == 1) ? (rem[1] > 0) :
                      (lockMode == 2) ? ($urandom_range(0, 4) == 0) : 1'b0;
            @(negedge fpga_clk);
            if (m0_ack) begin ackOrder.push_back(0); rem[0]--; need[0] = 1; end
            if (m1_ack) begin ackOrder.push_back(1); rem[1]--; need[1] = 1; end
        end
        if (rem[0] > 0 || rem[1] > 0) begin
            total++; bad++;
            $display("[TB] FAIL traffic_timeout: remaining m0=%0d m1=%0d, required 0", rem[0], rem[1]);
        end
        @(posedge fpga_clk); #1;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        m1_lock = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainProc
        int lat, weCnt, weK, weA;
        logic [31:0] rd, weD;
        logic er;
        int expAlt[8];
        int expLock[8];
        expAlt  = '{0, 1, 0, 1, 0, 1, 0, 1};
        expLock = '{1, 1, 1, 1, 0, 0, 0, 0};

        repeat (3) @(posedge fpga_clk);
        #1;
        modelOn = 1;
        @(negedge fpga_clk);
        checkBit("rst_m0_ack", m0_ack, 1'b0);
        checkBit("rst_m1_ack", m1_ack, 1'b0);
        checkBit("rst_m0_err", m0_err, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_dram_we", dram_we, 1'b0);
        checkOutput("rst_dram_a", 32'(dram_a), 32'h0);
        checkOutput("rst_dram_d", dram_d, 32'h0);
        checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
        checkOutput("rst_m1_rdata", m1_rdata, 32'h0);
        @(posedge fpga_clk); #1;
        fpga_rst = 0;

        singleTx(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, rd, er, weCnt, weK, weD, weA);
        checkOutput("fullwr_lat", 32'(lat), 32'd2);
        checkOutput("fullwr_wecnt", 32'(weCnt), 32'd1);
        checkOutput("fullwr_d", weD, 32'hDEADBEEF);
        checkOutput("fullwr_a", 32'(weA), 32'd4);

        singleTx(0, 1'b0, 32'h10, 4'h0, 32'h0, lat, rd, er, weCnt, weK, weD, weA);
        checkOutput("read_lat", 32'(lat), 32'd2);
        checkOutput("read_data", rd, 32'hDEADBEEF);
        checkBit("read_err", er, 1'b0);
        checkOutput("read_wecnt", 32'(weCnt), 32'd0);

        singleTx(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, lat, rd, er, weCnt, weK, weD, weA);
        singleTx(0, 1'b1, 32'h20, 4'b0010, 32'h0000_AB00, lat, rd, er, weCnt, weK, weD, weA);
        checkOutput("rmw_lat", 32'(lat), 32'd3);
        checkOutput("rmw_wecnt", 32'(weCnt), 32'd1);
        checkOutput("rmw_wecycle", 32'(weK), 32'd2);
        checkOutput("rmw_d", weD, 32'h1122_AB44);
        checkOutput("rmw_rdata", rd, 32'h0);
        singleTx(0, 1'b0, 32'h20, 4'h0, 32'h0, lat, rd, er, weCnt, weK, weD, weA);
        checkOutput("rmw_readback", rd, 32'h1122_AB44);

        @(posedge fpga_clk); #1;
        fpga_rst = 1;
        repeat (2) @(posedge fpga_clk);
        #1;
        fpga_rst = 0;
        traffic(4, 4, 0, 0);
        checkOutput("alt_count", 32'(ackOrder.size()), 32'd8);
        for (int i = 0; i < 8 && i < ackOrder.size(); i++)
            checkOutput($sformatf("alt_order%0d", i), 32'(ackOrder[i]), 32'(expAlt[i]));

        traffic(4, 4, 1, 0);
        checkOutput("lock_count", 32'(ackOrder.size()), 32'd8);
        for (int i = 0; i < 8 && i < ackOrder.size(); i++)
            checkOutput($sformatf("lock_order%0d", i), 32'(ackOrder[i]), 32'(expLock[i]));

        singleTx(1, 1'b1, 32'h0001_0000, 4'hF, 32'hCAFE_F00D, lat, rd, er, weCnt, weK, weD, weA);
        checkOutput("oor_lat", 32'(lat), 32'd2);
        checkBit("oor_err", er, 1'b1);
        checkOutput("oor_rdata", rd, 32'h0);
        checkOutput("oor_wecnt", 32'(weCnt), 32'd0);
        singleTx(1, 1'b0, 32'h0000_FFFC, 4'h0, 32'h0, lat, rd, er, weCnt, weK, weD, weA);
        checkBit("lastword_err", er, 1'b0);
        checkOutput("lastword_rdata", rd, initWord(DEPTH - 1));

        @(posedge fpga_clk); #1;
        applyStimulus(0, 1'b1, 1'b1, 32'h30, 4'b0001, 32'h0000_00EE);
        @(posedge fpga_clk); #1;
        @(posedge fpga_clk); #1;
        fpga_rst = 1;
        @(negedge fpga_clk);
        checkBit("rstrmw_we", dram_we, 1'b0);
        checkBit("rstrmw_ack", m0_ack, 1'b0);
        @(posedge fpga_clk); #1;
        fpga_rst = 0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge fpga_clk);
        checkBit("rstrmw_busy", busy, 1'b0);
        checkBit("rstrmw_we2", dram_we, 1'b0);
        checkBit("rstrmw_ack2", m0_ack, 1'b0);
        checkOutput("rstrmw_a", 32'(dram_a), 32'h0);
        checkOutput("rstrmw_d", dram_d, 32'h0);
        singleTx(0, 1'b0, 32'h30, 4'h0, 32'h0, lat, rd, er, weCnt, weK, weD, weA);
        checkOutput("rstrmw_unchanged", rd, initWord(12));

        traffic(60, 60, 2, 1);

        repeat (4) @(posedge fpga_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
